// File: rtl/dyn_resize.sv
// dyn_resize: parallel fixed-point requantiser with a frame-synchronous
// run-time shift, selectable rounding, saturate/wrap overflow handling,
// sticky per-lane overflow flags and a saturating overflow-event counter.
module dyn_resize #(
    parameter int    DIN_WIDTH  = 18,
    parameter int    DIN_POINT  = 16,
    parameter string DATA_TYPE  = "signed",
    parameter int    PARALLEL   = 4,
    parameter int    MAX_SHIFT  = 8,
    parameter int    SHIFT_INIT = 0,
    parameter int    DOUT_WIDTH = 9,
    parameter int    DOUT_POINT = 8,
    parameter string ROUND_MODE = "even",
    parameter int    SATURATE   = 1,
    parameter int    CNT_WIDTH  = 16,
    parameter int    DELAY      = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [DIN_WIDTH*PARALLEL-1:0]        din,
    input  logic                                 din_valid,
    input  logic                                 sync_in,
    input  logic signed [$clog2(MAX_SHIFT+1):0]  shift_in,
    input  logic                                 clr_cnt,
    output logic [DOUT_WIDTH*PARALLEL-1:0]       dout,
    output logic                                 dout_valid,
    output logic                                 sync_out,
    output logic                                 warning,
    output logic [PARALLEL-1:0]                  ovf_lanes,
    output logic [CNT_WIDTH-1:0]                 ovf_count,
    output logic                                 cfg_err
);

    localparam int SW        = $clog2(MAX_SHIFT + 1) + 1;
    localparam bit IS_SIGNED = (DATA_TYPE == "signed");
    localparam bit RND_EVEN  = (ROUND_MODE == "even");
    // Fraction bits dropped: the output point shift plus the MAX_SHIFT guard
    // bits that keep right shifts exact in the wide intermediate.
    localparam int FRAC_DROP = DIN_POINT - DOUT_POINT + MAX_SHIFT;
    // Exact din*2^shift needs DIN_WIDTH+2*MAX_SHIFT bits; one extra bit makes
    // unsigned data representable as signed and one more absorbs rounding carry.
    localparam int WX        = DIN_WIDTH + 2 * MAX_SHIFT + 2;
    localparam int BW        = DOUT_WIDTH * PARALLEL + 4;

    localparam logic signed [WX-1:0] ONE_X = 1;
    localparam logic signed [WX-1:0] HI_X  = IS_SIGNED ? (ONE_X <<< (DOUT_WIDTH - 1)) - ONE_X
                                                       : (ONE_X <<< DOUT_WIDTH) - ONE_X;
    localparam logic signed [WX-1:0] LO_X  = IS_SIGNED ? -(ONE_X <<< (DOUT_WIDTH - 1)) : '0;
    localparam logic signed [SW-1:0] SH_MAX    = SW'(MAX_SHIFT);
    localparam logic signed [SW-1:0] SH_MIN    = -SH_MAX;
    localparam logic signed [SW-1:0] SHIFT_RST = SW'(SHIFT_INIT);

    // {clamped, value}: limit a requested shift to +/-MAX_SHIFT
    function automatic logic [SW:0] clamp_shift(input logic signed [SW-1:0] s);
        if (s > SH_MAX)      return {1'b1, SH_MAX};
        else if (s < SH_MIN) return {1'b1, SH_MIN};
        else                 return {1'b0, s};
    endfunction

    // Sign or zero extend one input lane into the wide signed domain
    function automatic logic signed [WX-1:0] extend_lane(input logic [DIN_WIDTH-1:0] x);
        if (IS_SIGNED) return WX'(signed'(x));
        else           return WX'(x);
    endfunction

    // Drop FRAC_DROP bits: floor, or round half to even
    function automatic logic signed [WX-1:0] round_lane(input logic signed [WX-1:0] v);
        logic signed [WX-1:0] q;
        logic signed [WX-1:0] frac;
        logic signed [WX-1:0] half2;
        q = v >>> FRAC_DROP;
        if (RND_EVEN) begin
            frac  = v - (q <<< FRAC_DROP);
            half2 = ONE_X <<< FRAC_DROP;
            if (((frac <<< 1) > half2) || (((frac <<< 1) == half2) && q[0]))
                q = q + ONE_X;
        end
        return q;
    endfunction

    // {overflow, value}: clamp or wrap into the output range
    function automatic logic [DOUT_WIDTH:0] range_lane(input logic signed [WX-1:0] v);
        if (v > HI_X) begin
            if (SATURATE != 0) return {1'b1, HI_X[DOUT_WIDTH-1:0]};
            else               return {1'b1, v[DOUT_WIDTH-1:0]};
        end else if (v < LO_X) begin
            if (SATURATE != 0) return {1'b1, LO_X[DOUT_WIDTH-1:0]};
            else               return {1'b1, v[DOUT_WIDTH-1:0]};
        end
        return {1'b0, v[DOUT_WIDTH-1:0]};
    endfunction

    logic signed [SW-1:0]   act_shift_q, act_shift_d;
    logic [SW:0]            shift_chk;
    logic                   cerr_d;
    int                     amt;
    logic signed [WX-1:0]   wide_d    [PARALLEL];
    logic signed [WX-1:0]   wide_p1_q [PARALLEL];
    logic                   vld_p1_q, sync_p1_q, cerr_p1_q;
    logic signed [WX-1:0]   rnd_p2_q  [PARALLEL];
    logic                   vld_p2_q, sync_p2_q, cerr_p2_q;
    logic [DOUT_WIDTH:0]    rng;
    logic [PARALLEL-1:0]    ovf_p3_d;
    logic [DOUT_WIDTH*PARALLEL-1:0] dout_p3_d, dout_p3_q;
    logic                   vld_p3_q, sync_p3_q, warn_p3_q, cerr_p3_q;
    logic [PARALLEL-1:0]    ovf_lanes_q, ovf_lanes_d;
    logic [CNT_WIDTH-1:0]   ovf_count_q, ovf_count_d;
    logic [BW-1:0]          out_p3, out_fin;

    // Shift selection and exact widening; a sync sample already uses the new shift
    always_comb begin
        shift_chk   = clamp_shift(shift_in);
        act_shift_d = sync_in ? shift_chk[SW-1:0] : act_shift_q;
        cerr_d      = sync_in & shift_chk[SW];
        amt         = int'(act_shift_d) + MAX_SHIFT;
        for (int i = 0; i < PARALLEL; i++)
            wide_d[i] = extend_lane(din[i*DIN_WIDTH +: DIN_WIDTH]) <<< amt;
    end

    // Active shift register, reloaded on every sync_in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) act_shift_q <= SHIFT_RST;
        else        act_shift_q <= act_shift_d;
    end

    // Stage 1: exact shifted value plus control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            sync_p1_q <= 1'b0;
            cerr_p1_q <= 1'b0;
            for (int i = 0; i < PARALLEL; i++) wide_p1_q[i] <= '0;
        end else begin
            vld_p1_q  <= din_valid;
            sync_p1_q <= sync_in;
            cerr_p1_q <= cerr_d;
            for (int i = 0; i < PARALLEL; i++) wide_p1_q[i] <= wide_d[i];
        end
    end

    // Stage 2: rounded value at the output binary point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            sync_p2_q <= 1'b0;
            cerr_p2_q <= 1'b0;
            for (int i = 0; i < PARALLEL; i++) rnd_p2_q[i] <= '0;
        end else begin
            vld_p2_q  <= vld_p1_q;
            sync_p2_q <= sync_p1_q;
            cerr_p2_q <= cerr_p1_q;
            for (int i = 0; i < PARALLEL; i++) rnd_p2_q[i] <= round_lane(wide_p1_q[i]);
        end
    end

    // Range check and overflow bookkeeping next-state; clr_cnt wins over events
    always_comb begin
        rng         = '0;
        ovf_p3_d    = '0;
        dout_p3_d   = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            rng         = range_lane(rnd_p2_q[i]);
            ovf_p3_d[i] = rng[DOUT_WIDTH];
            dout_p3_d[i*DOUT_WIDTH +: DOUT_WIDTH] = rng[DOUT_WIDTH-1:0];
        end
        ovf_lanes_d = ovf_lanes_q;
        ovf_count_d = ovf_count_q;
        if (clr_cnt) begin
            ovf_lanes_d = '0;
            ovf_count_d = '0;
        end else if (vld_p2_q) begin
            ovf_lanes_d = ovf_lanes_q | ovf_p3_d;
            if ((|ovf_p3_d) && (ovf_count_q != '1))
                ovf_count_d = ovf_count_q + CNT_WIDTH'(1);
        end
    end

    // Stage 3: output sample, alignment flags and warning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_p3_q <= '0;
            vld_p3_q  <= 1'b0;
            sync_p3_q <= 1'b0;
            warn_p3_q <= 1'b0;
            cerr_p3_q <= 1'b0;
        end else begin
            dout_p3_q <= dout_p3_d;
            vld_p3_q  <= vld_p2_q;
            sync_p3_q <= sync_p2_q;
            warn_p3_q <= vld_p2_q & (|ovf_p3_d);
            cerr_p3_q <= cerr_p2_q;
        end
    end

    // Sticky lane flags and saturating event counter (not delayed)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_lanes_q <= '0;
            ovf_count_q <= '0;
        end else begin
            ovf_lanes_q <= ovf_lanes_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign out_p3 = {dout_p3_q, vld_p3_q, sync_p3_q, warn_p3_q, cerr_p3_q};

    generate
        if (DELAY > 0) begin : g_dly
            logic [BW-1:0] dly_q [DELAY];
            // Optional output retiming chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DELAY; k++) dly_q[k] <= '0;
                end else begin
                    dly_q[0] <= out_p3;
                    for (int k = 1; k < DELAY; k++) dly_q[k] <= dly_q[k-1];
                end
            end
            assign out_fin = dly_q[DELAY-1];
        end else begin : g_nodly
            assign out_fin = out_p3;
        end
    endgenerate

    assign {dout, dout_valid, sync_out, warning, cfg_err} = out_fin;
    assign ovf_lanes = ovf_lanes_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_dyn_resize.sv
// Bench for dyn_resize: two instances (default even/saturate, and
// trunc/wrap with one extra output register) driven by the same stimulus
// and compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dyn_resize;

    localparam int DW = 18;
    localparam int P  = 4;
    localparam int OW = 9;
    localparam int MS = 8;
    localparam int SW = $clog2(MS + 1) + 1;
    localparam int FD = (16 - 8) + MS;
    localparam int CW = 16;
    localparam longint HI = 255;
    localparam longint LO = -256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [DW*P-1:0] din = '0;
    logic din_valid = 1'b0, sync_in = 1'b0, clr_cnt = 1'b0;
    logic signed [SW-1:0] shift_in = '0;

    logic [OW*P-1:0] a_dout, b_dout;
    logic a_vld, a_sync, a_warn, a_cerr, b_vld, b_sync, b_warn, b_cerr;
    logic [P-1:0] a_ovfl, b_ovfl;
    logic [CW-1:0] a_cnt, b_cnt;

    always #5 clk = ~clk;

    dyn_resize u_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .sync_in(sync_in), .shift_in(shift_in), .clr_cnt(clr_cnt),
        .dout(a_dout), .dout_valid(a_vld), .sync_out(a_sync), .warning(a_warn),
        .ovf_lanes(a_ovfl), .ovf_count(a_cnt), .cfg_err(a_cerr)
    );

    dyn_resize #(.ROUND_MODE("trunc"), .SATURATE(0), .DELAY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .sync_in(sync_in), .shift_in(shift_in), .clr_cnt(clr_cnt),
        .dout(b_dout), .dout_valid(b_vld), .sync_out(b_sync), .warning(b_warn),
        .ovf_lanes(b_ovfl), .ovf_count(b_cnt), .cfg_err(b_cerr)
    );

    typedef struct packed {
        logic v, s, ce, wa, wb;
        logic [OW*P-1:0] da, db;
        logic [P-1:0] oa, ob;
    } hist_t;

    hist_t hist [8];
    int cyc = 0, act = 0, n_pass = 0, n_total = 0, n_fail = 0;
    logic [P-1:0] fa = '0, fb = '0;
    logic [CW-1:0] ka = '0, kb = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value in output LSBs = x * 2^sh / 2^(DIN_POINT-DOUT_POINT), then round and range
    function automatic void quant(input logic [DW-1:0] x, input int sh, input bit even,
                                  input bit sat, output logic [OW-1:0] y, output bit ovf);
        longint xv, n, d, q, r;
        xv = longint'(signed'(x));
        n  = xv * (longint'(1) << (sh + MS));
        d  = longint'(1) << FD;
        q  = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        r  = n - q * d;
        if (even && ((2 * r > d) || (2 * r == d && q[0]))) q = q + 1;
        ovf = (q > HI) || (q < LO);
        if (ovf && sat) q = (q > 0) ? HI : LO;
        y = q[OW-1:0];
    endfunction

    function automatic hist_t model(input bit v, input bit s, input bit ce, input int sh,
                                    input logic [DW*P-1:0] d);
        hist_t e;
        logic [OW-1:0] y;
        bit o;
        e = '0;
        e.v = v; e.s = s; e.ce = ce;
        for (int i = 0; i < P; i++) begin
            quant(d[i*DW +: DW], sh, 1'b1, 1'b1, y, o);
            e.da[i*OW +: OW] = y; e.oa[i] = o;
            quant(d[i*DW +: DW], sh, 1'b0, 1'b0, y, o);
            e.db[i*OW +: OW] = y; e.ob[i] = o;
        end
        e.wa = v && (e.oa != 0);
        e.wb = v && (e.ob != 0);
        return e;
    endfunction

    function automatic logic [DW*P-1:0] rand_din();
        logic [DW*P-1:0] d;
        logic [DW-1:0] x;
        d = '0;
        for (int i = 0; i < P; i++) begin
            x = DW'($urandom());
            if ($urandom_range(0, 2) != 0) x = DW'($signed(x[11:0]));
            d[i*DW +: DW] = x;
        end
        return d;
    endfunction

    function automatic logic [DW*P-1:0] l0(input logic [DW-1:0] x);
        logic [DW*P-1:0] d;
        d = '0;
        d[DW-1:0] = x;
        return d;
    endfunction

    // One clock: drive inputs, update model, compare outputs at the negedge
    task automatic step(input bit v, input bit s, input int sh, input logic [DW*P-1:0] d,
                        input bit clr);
        hist_t e, e3, ea, eb;
        bit ce;
        ce = 1'b0;
        din = d; din_valid = v; sync_in = s; shift_in = SW'(sh); clr_cnt = clr;
        if (s) begin
            ce  = (sh > MS) || (sh < -MS);
            act = (sh > MS) ? MS : ((sh < -MS) ? -MS : sh);
        end
        e = model(v, s, ce, act, d);
        hist[cyc % 8] = e;
        @(posedge clk);
        e3 = hist[(cyc + 6) % 8];
        if (clr) begin
            fa = '0; fb = '0; ka = '0; kb = '0;
        end else if (e3.v) begin
            fa = fa | e3.oa;
            fb = fb | e3.ob;
            if (e3.oa != 0 && ka != '1) ka = ka + 1'b1;
            if (e3.ob != 0 && kb != '1) kb = kb + 1'b1;
        end
        @(negedge clk);
        ea = hist[(cyc + 6) % 8];
        eb = hist[(cyc + 5) % 8];
        chk("a_valid", 64'(a_vld), 64'(ea.v));
        chk("a_sync", 64'(a_sync), 64'(ea.s));
        chk("a_warning", 64'(a_warn), 64'(ea.wa));
        chk("a_cfg_err", 64'(a_cerr), 64'(ea.ce));
        if (ea.v) chk("a_dout", 64'(a_dout), 64'(ea.da));
        chk("a_ovf_lanes", 64'(a_ovfl), 64'(fa));
        chk("a_ovf_count", 64'(a_cnt), 64'(ka));
        chk("b_valid", 64'(b_vld), 64'(eb.v));
        chk("b_sync", 64'(b_sync), 64'(eb.s));
        chk("b_warning", 64'(b_warn), 64'(eb.wb));
        chk("b_cfg_err", 64'(b_cerr), 64'(eb.ce));
        if (eb.v) chk("b_dout", 64'(b_dout), 64'(eb.db));
        chk("b_ovf_lanes", 64'(b_ovfl), 64'(fb));
        chk("b_ovf_count", 64'(b_cnt), 64'(kb));
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_dout"}, 64'(a_dout), 64'(0));
        chk({tag, "_a_flags"}, 64'({a_vld, a_sync, a_warn, a_cerr}), 64'(0));
        chk({tag, "_a_book"}, 64'({a_ovfl, a_cnt}), 64'(0));
        chk({tag, "_b_dout"}, 64'(b_dout), 64'(0));
        chk({tag, "_b_flags"}, 64'({b_vld, b_sync, b_warn, b_cerr}), 64'(0));
        chk({tag, "_b_book"}, 64'({b_ovfl, b_cnt}), 64'(0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) hist[i] = '0;
        act = 0; fa = '0; fb = '0; ka = '0; kb = '0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Directed rounding / saturation / shift scheduling
        step(1, 1, 0, l0(18'h08000), 0);
        step(1, 0, 0, l0(18'h00180), 0);
        step(1, 0, 0, l0(18'h00080), 0);
        chk("tp_half_a", 64'(a_dout[8:0]), 64'h080);
        step(1, 0, 0, l0(18'h3FF80), 0);
        chk("tp_even_1p5_a", 64'(a_dout[8:0]), 64'h002);
        chk("tp_half_b", 64'(b_dout[8:0]), 64'h080);
        step(1, 1, 2, l0(18'h08000), 0);
        chk("tp_even_0p5_a", 64'(a_dout[8:0]), 64'h000);
        chk("tp_trunc_1p5_b", 64'(b_dout[8:0]), 64'h001);
        step(1, 1, 1, l0(18'h30000), 0);
        chk("tp_even_neg_a", 64'(a_dout[8:0]), 64'h000);
        step(1, 0, -3, l0(18'h08000), 0);
        chk("tp_sat_hi_a", 64'(a_dout[8:0]), 64'h0FF);
        chk("tp_warn_a", 64'(a_warn), 64'(1));
        chk("tp_cnt1_a", 64'(a_cnt), 64'(1));
        chk("tp_trunc_neg_b", 64'(b_dout[8:0]), 64'h1FF);
        step(1, 1, -3, l0(18'h08000), 0);
        chk("tp_sat_lo_a", 64'(a_dout[8:0]), 64'h100);
        chk("tp_wrap_hi_b", 64'(b_dout[8:0]), 64'h000);
        step(1, 0, 0, l0(18'h08000), 0);
        chk("tp_wrap_lo_b", 64'(b_dout[8:0]), 64'h000);
        step(1, 0, 0, l0(18'h04000), 0);
        chk("tp_sync_shift_a", 64'(a_dout[8:0]), 64'h010);
        step(0, 1, 4, rand_din(), 0);
        chk("tp_held_shift_a", 64'(a_dout[8:0]), 64'h010);
        step(1, 1, -8, rand_din(), 0);
        step(1, 1, -16, rand_din(), 0);
        repeat (4) step(0, 0, 0, '0, 0);

        // Randomized traffic including clamped shifts and occasional clears
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 31)) - 16, rand_din(), $urandom_range(0, 40) == 0);

        // Clamp then counter saturation
        step(1, 1, 15, l0(18'h08000), 0);
        step(1, 0, 0, l0(18'h08000), 0);
        step(1, 0, 0, l0(18'h08000), 0);
        chk("tp_cfg_err_a", 64'(a_cerr), 64'(1));
        chk("tp_cfg_sync_a", 64'(a_sync), 64'(1));
        for (int k = 0; k < (1 << CW) + 5; k++) step(1, 0, 0, l0(18'h08000), 0);
        chk("tp_cnt_sat_a", 64'(a_cnt), 64'hFFFF);
        step(1, 0, 0, l0(18'h08000), 1);
        chk("tp_clr_cnt_a", 64'(a_cnt), 64'(0));
        chk("tp_clr_lanes_a", 64'(a_ovfl), 64'(0));
        step(1, 0, 0, l0(18'h08000), 0);
        chk("tp_after_clr_a", 64'(a_cnt), 64'(1));

        // Asynchronous reset during a valid stream
        for (int k = 0; k < 6; k++) step(1, k == 2, 3, rand_din(), 0);
        #2 rst_n = 1'b0;
        din_valid = 1'b0; sync_in = 1'b0; clr_cnt = 1'b0;
        #1 chk_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) step(1, 0, 0, rand_din(), 0);
        for (int k = 0; k < 60; k++)
            step($urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 31)) - 16, rand_din(), 0);
        repeat (4) step(0, 0, 0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dyn_resize.md
# dyn_resize

Parallel fixed-point requantiser for the RFI-detection datapath. It replaces the fixed-shift resize stage with a run-time shift applied only at frame boundaries (`sync_in`), selectable rounding, and saturate or wrap overflow handling. It also keeps per-lane sticky overflow flags and a saturating overflow-event counter for software readout. It sits between the FFT/power stages and the narrow-width detectors, PARALLEL lanes wide.

## Interface
- DIN_WIDTH, 18, input lane width
- DIN_POINT, 16, input binary point
- DATA_TYPE, "signed", "signed" or "unsigned" for input and output
- PARALLEL, 4, number of lanes
- MAX_SHIFT, 8, largest allowed |shift|
- SHIFT_INIT, 0, active shift after reset
- DOUT_WIDTH, 9, output lane width
- DOUT_POINT, 8, output binary point; DIN_POINT ≥ DOUT_POINT required
- ROUND_MODE, "even", "even" (round half to even) or "trunc" (floor)
- SATURATE, 1, 1 clamps on overflow, 0 wraps (keeps low DOUT_WIDTH bits)
- CNT_WIDTH, 16, width of overflow event counter
- DELAY, 0, extra register stages on dout/dout_valid/sync_out
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  DIN_WIDTH*PARALLEL  lane i at bits [i*DIN_WIDTH +: DIN_WIDTH]
- din_valid  in  1  qualifies din
- sync_in  in  1  frame-boundary pulse
- shift_in  in  SW = clog2(MAX_SHIFT+1)+1  signed; positive is <<, negative is >>
- clr_cnt  in  1  synchronous clear of ovf_count and ovf_lanes
- dout  out  DOUT_WIDTH*PARALLEL  requantised lanes
- dout_valid  out  1  qualifies dout
- sync_out  out  1  sync_in aligned to dout
- warning  out  1  pulse: some lane overflowed on this output sample
- ovf_lanes  out  PARALLEL  sticky per-lane overflow flags
- ovf_count  out  CNT_WIDTH  number of valid samples with ≥1 lane overflow, saturating
- cfg_err  out  1  pulse: shift_in was clamped at a sync load

## Operation
- Active shift register `act_shift`:
  - Loads shift_in on any cycle with sync_in=1.
  - The sample presented in the same cycle as sync_in already uses the new value.
  - Otherwise `act_shift` holds its value.
- Clamping: shift_in > MAX_SHIFT loads MAX_SHIFT; shift_in < −MAX_SHIFT loads −MAX_SHIFT. Either case pulses cfg_err with sync_out alignment.
- Stage 1: register din, valid and sync. Form an exact internal value of DIN_WIDTH+2*MAX_SHIFT bits, equal to din·2^act_shift. Use sign extension when signed, zero extension when unsigned. No bits are lost.
- Stage 2: drop F = DIN_POINT−DOUT_POINT fractional bits.
  - "trunc": floor, i.e. an arithmetic right shift.
  - "even": add half an LSB; on an exact tie, round to the even result.
  - Rounding carry is included in the overflow check.
- Stage 3: range check against the DOUT range.
  - Signed range: [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1]. Unsigned range: [0, 2^DOUT_WIDTH−1].
  - On overflow with SATURATE=1, output the nearest bound. With SATURATE=0, output the low DOUT_WIDTH bits.
  - A lane overflow flag is raised either way.
- Overflow bookkeeping happens only on stage-3 samples with valid=1; invalid samples never set flags or count.
  - warning = OR of the lane flags.
  - ovf_lanes[i] is sticky.
  - ovf_count increments by 1 per sample, however many lanes overflowed, and holds at all-ones.
- clr_cnt has priority over a same-cycle increment or flag set: counter and flags become 0, and the overflow event in that cycle is lost.
- dout, dout_valid, sync_out, warning and cfg_err then pass through DELAY registers. ovf_lanes and ovf_count are not delayed.

## Timing
- Latency din→dout is 3+DELAY cycles. Valid, sync, warning and cfg_err keep identical alignment.
- Throughput: one sample per lane per cycle. There is no backpressure.
- Reset (rst_n=0, asynchronous):
  - All pipeline and DELAY registers clear to 0.
  - dout=0, dout_valid=0, sync_out=0, warning=0, cfg_err=0, ovf_lanes=0, ovf_count=0.
  - act_shift=SHIFT_INIT.
- Release of rst_n is synchronised by the system. The first valid output appears 3+DELAY cycles after the first din_valid.
- Reset mid-frame discards in-flight samples. No partial sample may appear after release.
- Back-to-back sync_in pulses each reload act_shift.
- dout contents while dout_valid=0 are don't-care but deterministic.

## Test plan
- Defaults, shift 0, "even": din lane0=0x08000 (0.5) → dout lane0=0x080 exactly 3 cycles later, dout_valid=1, warning=0.
- Rounding, shift 0:
  - din=0x00180 → 0x002 in "even", 0x001 in "trunc".
  - din=0x00080 → 0x000 in "even".
  - din=0x3FF80 (−0.5 LSB) → 0x000 in "even", 0x1FF in "trunc".
- Saturation:
  - sync_in with shift_in=+2, din=0x08000 → dout=0x0FF, warning=1, ovf_lanes[0]=1, ovf_count=1.
  - din=0x30000 (−1.0) with shift +1 → dout=0x100.
  - With SATURATE=0, the same two inputs wrap to 0x000 and 0x000.
- Shift scheduling: shift_in=−3 held with sync_in=0 → no effect. Pulse sync_in with shift_in=−3 on a sample of 0x08000 → that sample gives 0x010, and the following samples also use −3.
- Clamp and counter: sync_in with shift_in=+15 (MAX_SHIFT=8) → cfg_err pulse aligned with sync_out, act_shift=8.
  - Run 2^CNT_WIDTH+5 overflowing valid samples → ovf_count stops at 0xFFFF.
  - Assert clr_cnt together with an overflow → count=0 and flags=0.
- Reset: assert rst_n=0 during a valid stream → all outputs 0 immediately (asynchronously). After release, act_shift=SHIFT_INIT and no stale dout_valid appears.
